// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider sequencing controller: FSM state encodings,
// divider start/stop levels and default widths/drain length.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIVC_IDLE  = 2'd0,
    DIVC_BUSY  = 2'd1,
    DIVC_DONE  = 2'd2,
    DIVC_DRAIN = 2'd3
  } divc_state_t;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam int DIVC_DATA_W    = 32;
  localparam int DIVC_DRAIN_CYC = 2;

endpackage : div_ctrl_pkg

// File: rtl/div_ctrl.sv
// Sequences DIV/DIVU requests from EX onto the iterative divider and stalls the pipe until done.
// Optional build macro DIV_CTRL_ZERO_FAST_EN: zero divisors complete in one cycle without the divider.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W    = DIVC_DATA_W,
  parameter int DRAIN_CYC = DIVC_DRAIN_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_div_req_i,
  input  logic                ex_div_signed_i,
  input  logic [DATA_W-1:0]   ex_op1_i,
  input  logic [DATA_W-1:0]   ex_op2_i,
  input  logic                flush_i,
  input  logic                div_ready_i,
  input  logic [2*DATA_W-1:0] div_result_i,
  output logic                div_start_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   div_op1_o,
  output logic [DATA_W-1:0]   div_op2_o,
  output logic                div_discard_o,
  output logic                stall_req_o,
  output logic                res_valid_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                busy_o
);

  localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  divc_state_t       r_state;
  logic              r_start;
  logic              r_signed;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [CW-1:0]     r_drain_cnt;

  logic w_zero_div;
  logic w_stall;

`ifdef DIV_CTRL_ZERO_FAST_EN
  assign w_zero_div = (ex_op2_i == '0);
`else
  assign w_zero_div = 1'b0;
`endif

  // Stall is partly combinational so EX sees it in the same cycle it presents the request.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      DIVC_IDLE:  w_stall = ex_div_req_i & ~flush_i;
      DIVC_BUSY:  w_stall = ~flush_i;
      DIVC_DONE:  w_stall = 1'b0;
      DIVC_DRAIN: w_stall = ex_div_req_i;
      default:    w_stall = 1'b0;
    endcase
  end

  assign stall_req_o   = w_stall & ~rst;
  assign div_discard_o = (r_state == DIVC_BUSY) & flush_i;
  assign res_valid_o   = (r_state == DIVC_DONE);
  assign busy_o        = (r_state != DIVC_IDLE);
  assign div_start_o   = r_start;
  assign div_signed_o  = r_signed;
  assign div_op1_o     = r_op1;
  assign div_op2_o     = r_op2;
  assign hi_o          = r_hi;
  assign lo_o          = r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= DIVC_IDLE;
      r_start     <= DIV_STOP;
      r_signed    <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        DIVC_IDLE: begin
          if (ex_div_req_i && !flush_i) begin
            r_op1    <= ex_op1_i;
            r_op2    <= ex_op2_i;
            r_signed <= ex_div_signed_i;
            if (w_zero_div) begin
              r_hi    <= '0;
              r_lo    <= '0;
              r_state <= DIVC_DONE;
            end else begin
              r_start <= DIV_START;
              r_state <= DIVC_BUSY;
            end
          end
        end
        DIVC_BUSY: begin
          // A flush wins over a coincident ready: the result is dropped.
          if (flush_i) begin
            r_start     <= DIV_STOP;
            r_drain_cnt <= CW'(DRAIN_CYC - 1);
            r_state     <= DIVC_DRAIN;
          end else if (div_ready_i) begin
            r_hi    <= div_result_i[2*DATA_W-1:DATA_W];
            r_lo    <= div_result_i[DATA_W-1:0];
            r_start <= DIV_STOP;
            r_state <= DIVC_DONE;
          end
        end
        DIVC_DONE: begin
          r_state <= DIVC_IDLE;
        end
        DIVC_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state <= DIVC_IDLE;
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end
        default: r_state <= DIVC_IDLE;
      endcase
    end
  end

endmodule : div_ctrl

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed divisions against a behavioural divider stub,
// expected results pushed at issue and checked by an independent monitor on res_valid_o.
module tb_div_ctrl;

  localparam int W   = 32;
  localparam int LAT = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_div_req_i = 1'b0;
  logic          ex_div_signed_i = 1'b0;
  logic [W-1:0]  ex_op1_i = '0;
  logic [W-1:0]  ex_op2_i = '0;
  logic          flush_i = 1'b0;
  logic          div_ready_i;
  logic [2*W-1:0] div_result_i;
  logic          div_start_o, div_signed_o, div_discard_o, stall_req_o, res_valid_o, busy_o;
  logic [W-1:0]  div_op1_o, div_op2_o, hi_o, lo_o;

  div_ctrl #(.DATA_W(W), .DRAIN_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .ex_div_req_i(ex_div_req_i), .ex_div_signed_i(ex_div_signed_i),
    .ex_op1_i(ex_op1_i), .ex_op2_i(ex_op2_i), .flush_i(flush_i),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_discard_o(div_discard_o),
    .stall_req_o(stall_req_o), .res_valid_o(res_valid_o),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Behavioural iterative divider: result after LAT cycles of start, held until start drops.
  int            div_cnt;
  logic          m_ready;
  logic [2*W-1:0] m_result;
  assign div_ready_i  = m_ready;
  assign div_result_i = m_result;

  function automatic logic [2*W-1:0] div_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] q, r;
    if (b == '0) return '0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= 0;
      m_ready  <= 1'b0;
      m_result <= '0;
    end else if (div_discard_o || !div_start_o) begin
      div_cnt <= 0;
      m_ready <= 1'b0;
    end else if (div_cnt == LAT) begin
      m_ready  <= 1'b1;
      m_result <= div_ref(div_op1_o, div_op2_o, div_signed_o);
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  typedef struct packed { logic [W-1:0] hi; logic [W-1:0] lo; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_starts = 0;
  logic prev_start = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: pops one expected pair for every result pulse and counts divider starts.
  always @(negedge clk) begin
    if (!rst) begin
      if (div_start_o && !prev_start) n_starts++;
      if (res_valid_o) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: got hi=0x%0h lo=0x%0h expected no result", hi_o, lo_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (hi_o !== e.hi || lo_o !== e.lo) begin
            n_err++;
            $display("FAIL result: got hi=0x%0h lo=0x%0h expected hi=0x%0h lo=0x%0h", hi_o, lo_o, e.hi, e.lo);
          end else begin
            $display("ok   result: hi=0x%0h lo=0x%0h", hi_o, lo_o);
          end
        end
      end
    end
    prev_start = div_start_o;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    ex_op1_i        = a;
    ex_op2_i        = b;
    ex_div_signed_i = s;
    ex_div_req_i    = 1'b1;
  endtask

  // Steps until res_valid_o is seen; returns cycles taken and whether stall/start held in between.
  task automatic wait_done(output int ncyc, output bit held);
    held = 1'b1;
    ncyc = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      ncyc++;
      if (res_valid_o) return;
      held &= (stall_req_o === 1'b1) && (div_start_o === 1'b1);
    end
    n_cmp++;
    n_err++;
    $display("FAIL timeout: got no res_valid_o in 100 cycles expected one");
    ncyc = -1;
  endtask

  initial begin
    int  nc;
    bit  held;
    int  s0;

    #2;
    check("reset_outputs", {div_start_o, div_signed_o, div_discard_o, stall_req_o, res_valid_o, busy_o,
                            hi_o, lo_o}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    // DIV 100 / 7
    exp_q.push_back({32'd2, 32'd14});
    issue(32'd100, 32'd7, 1'b1);
    #1 check("idle_stall_comb", stall_req_o, 1);
    wait_done(nc, held);
    check("busy_stall_start_held", held, 1);
    check("done_start_low", div_start_o, 0);
    check("done_stall_low", stall_req_o, 0);
    ex_div_req_i = 1'b0;
    step();
    check("hi_hold", hi_o, 32'd2);
    check("idle_after_done", busy_o, 0);

    // Signed -7 / 2 and unsigned 0xFFFFFFFF / 1
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(nc, held);
    ex_div_req_i = 1'b0;
    step();
    exp_q.push_back({32'd0, 32'hFFFF_FFFF});
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done(nc, held);
    ex_div_req_i = 1'b0;
    step();

    // Request held through DONE, then back-to-back DIVU 9 / 3
    s0 = n_starts;
    exp_q.push_back({32'd2, 32'd6});
    issue(32'd50, 32'd8, 1'b0);
    wait_done(nc, held);
    step();
    check("no_reissue_from_done", {busy_o, div_start_o}, 0);
    exp_q.push_back({32'd0, 32'd3});
    issue(32'd9, 32'd3, 1'b0);
    wait_done(nc, held);
    ex_div_req_i = 1'b0;
    step();
    check("b2b_issue_count", n_starts - s0, 2);

    // Flush at cycle 10 of BUSY, new request stalled through DRAIN
    s0 = n_starts;
    issue(32'd1000, 32'd3, 1'b0);
    repeat (11) step();
    flush_i = 1'b1;
    #1;
    check("flush_discard", div_discard_o, 1);
    check("flush_stall_low", stall_req_o, 0);
    step();
    flush_i = 1'b0;
    exp_q.push_back({32'd1, 32'd11});
    issue(32'd45, 32'd4, 1'b0);
    #1;
    check("drain1", {busy_o, stall_req_o, div_start_o}, 3'b110);
    step();
    check("drain2", {busy_o, stall_req_o, div_start_o}, 3'b110);
    step();
    check("drain_to_idle", {busy_o, stall_req_o, div_start_o}, 3'b010);
    wait_done(nc, held);
    ex_div_req_i = 1'b0;
    step();
    check("flush_reissue_count", n_starts - s0, 2);

    // Divide by zero
    s0 = n_starts;
    exp_q.push_back({32'd0, 32'd0});
    issue(32'd5, 32'd0, 1'b1);
    wait_done(nc, held);
    ex_div_req_i = 1'b0;
`ifdef DIV_CTRL_ZERO_FAST_EN
    check("zero_fast_latency", nc, 1);
    check("zero_fast_no_start", n_starts - s0, 0);
`else
    check("zero_via_divider", n_starts - s0, 1);
`endif
    step();

    // Async reset mid-BUSY
    issue(32'd77, 32'd5, 1'b0);
    repeat (6) step();
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {div_start_o, div_signed_o, div_discard_o, stall_req_o, res_valid_o, busy_o,
                                hi_o, lo_o}, '0);
    check("async_rst_ops", {div_op1_o, div_op2_o}, '0);
    ex_div_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    exp_q.push_back({32'd2, 32'd15});
    issue(32'd77, 32'd5, 1'b0);
    wait_done(nc, held);
    ex_div_req_i = 1'b0;
    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule : tb_div_ctrl
